// File: rtl/mystic_uart_pkg.sv
// Shared types and constants for the mystic UART transmitter.
package mystic_uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam int   BIT_IDX_W  = $clog2(DATA_BITS);
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mystic_uart_baud_cnt.sv
// Loadable bit-period counter: strobes o_bit_end on the last of every D cycles.
import mystic_uart_pkg::*;

module mystic_uart_baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_bit_end
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_last;
  logic [DIV_W-1:0] w_last_load;

  // Store D-1 rather than D so the counter never needs to reach 2^DIV_W-1+1.
  assign w_last_load = (i_div == '0) ? '0 : (i_div - ONE);
  assign o_bit_end   = i_en && (r_cnt == r_last);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt  <= '0;
      r_last <= '0;
    end else if (i_load) begin
      r_cnt  <= '0;
      r_last <= w_last_load;
    end else if (i_en) begin
      r_cnt  <= o_bit_end ? '0 : (r_cnt + ONE);
    end
  end

endmodule

// File: rtl/mystic_uart_tx.sv
// 8N1 UART transmitter with runtime baud divisor; define UART_TX_PARITY_EN
// to insert an even-parity bit between the data bits and the stop bit.
import mystic_uart_pkg::*;

module mystic_uart_tx #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [7:0]       din_i,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             tx_start_i,
  output logic             tx_o,
  output logic             tx_done_tick_o
);

  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_ONE  = BIT_IDX_W'(1);

  state_t                 r_state, w_state_next;
  logic [DATA_BITS-1:0]   r_shift, w_shift_next;
  logic [BIT_IDX_W-1:0]   r_bit_idx, w_bit_idx_next;
  logic                   r_done, w_done_next;
  logic                   w_load;
  logic                   w_bit_end;
  logic                   w_tx;
`ifdef UART_TX_PARITY_EN
  logic                   r_parity, w_parity_next;
`endif

  mystic_uart_baud_cnt #(
    .DIV_W (DIV_W)
  ) u_baud_cnt (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .i_load    (w_load),
    .i_en      (r_state != IDLE),
    .i_div     (baud_div),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_done    <= w_done_next;
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parity_next;
`endif
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_done_next    = 1'b0;
    w_load         = 1'b0;
    w_tx           = IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
    w_parity_next  = r_parity;
`endif
    case (r_state)
      IDLE: begin
        if (tx_start_i) begin
          w_load       = 1'b1;
          w_shift_next = din_i;
          w_state_next = START;
`ifdef UART_TX_PARITY_EN
          w_parity_next = even_parity(din_i);
`endif
        end
      end
      START: begin
        w_tx = 1'b0;
        if (w_bit_end) begin
          w_state_next   = DATA;
          w_bit_idx_next = '0;
        end
      end
      DATA: begin
        w_tx = r_shift[0];
        if (w_bit_end) begin
          w_shift_next   = r_shift >> 1;
          w_bit_idx_next = r_bit_idx + IDX_ONE;
          if (r_bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        w_tx = r_parity;
        if (w_bit_end) begin
          w_state_next = STOP;
        end
      end
`endif
      STOP: begin
        // Done is registered, so it lands in the first IDLE cycle where a new start is accepted.
        if (w_bit_end) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign tx_o           = w_tx;
  assign tx_done_tick_o = r_done;

endmodule

// File: tb/tb_mystic_uart_tx.sv
// Self-checking bench for mystic_uart_tx: scoreboard of expected frames, serial-line monitor.
module tb_mystic_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int STOP_IDX = NB - 1;

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [7:0]  din_i = 8'h00;
  logic [15:0] baud_div = 16'd4;
  logic        tx_start_i = 1'b0;
  logic        tx_o;
  logic        tx_done_tick_o;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  mystic_uart_tx #(
    .DIV_W (16)
  ) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .din_i          (din_i),
    .baud_div       (baud_div),
    .tx_start_i     (tx_start_i),
    .tx_o           (tx_o),
    .tx_done_tick_o (tx_done_tick_o)
  );

  task automatic drive_start(input logic [7:0] b, input int div, input bit push);
    exp_t e;
    if (push) begin
      e.data = b;
      e.div  = div;
      sb.push_back(e);
    end
    $display("drive: byte=0x%02h baud_div=%0d", b, div);
    din_i      = b;
    baud_div   = 16'(div);
    tx_start_i = 1'b1;
    @(negedge clk_i);
    tx_start_i = 1'b0;
  endtask

  // Waits for a start bit, samples every cycle of the frame, pops the scoreboard and compares.
  task automatic capture_frame(input string name, output int gap);
    exp_t        e;
    int          d;
    int          glitch;
    int          early;
    logic [10:0] bits;
    logic [7:0]  got;
    gap = 0;
    while (tx_o !== 1'b0 && gap < 100) begin
      gap++;
      @(negedge clk_i);
    end
    checks++;
    if (tx_o !== 1'b0) begin
      errors++;
      $display("FAIL %s start: tx_o=%b after %0d cycles, required 0", name, tx_o, gap);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: frame seen, required none pending", name);
      return;
    end
    e      = sb.pop_front();
    d      = (e.div == 0) ? 1 : e.div;
    bits   = '1;
    glitch = 0;
    early  = 0;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < d; c++) begin
        if (b != 0 || c != 0) @(negedge clk_i);
        if (c == 0) bits[b] = tx_o;
        else if (tx_o !== bits[b]) glitch++;
        if (tx_done_tick_o !== 1'b0) early++;
      end
    end
    @(negedge clk_i);
    got = bits[8:1];
    $display("frame %s: byte=0x%02h expected=0x%02h div=%0d gap=%0d", name, got, e.data, e.div, gap);
    checks++;
    if (got !== e.data) begin
      errors++;
      $display("FAIL %s data: got 0x%02h, required 0x%02h", name, got, e.data);
    end
`ifdef UART_TX_PARITY_EN
    checks++;
    if (bits[9] !== ^e.data) begin
      errors++;
      $display("FAIL %s parity: got %b, required %b", name, bits[9], ^e.data);
    end
`endif
    checks++;
    if (bits[STOP_IDX] !== 1'b1) begin
      errors++;
      $display("FAIL %s stop: got %b, required 1", name, bits[STOP_IDX]);
    end
    checks++;
    if (glitch !== 0) begin
      errors++;
      $display("FAIL %s bit_hold: %0d level changes inside bits, required 0", name, glitch);
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL %s done_early: %0d done cycles inside frame, required 0", name, early);
    end
    checks++;
    if (tx_done_tick_o !== 1'b1) begin
      errors++;
      $display("FAIL %s done: got %b at cycle %0d, required 1", name, tx_done_tick_o, NB * d);
    end
    @(negedge clk_i);
    checks++;
    if (tx_done_tick_o !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width: got %b one cycle later, required 0", name, tx_done_tick_o);
    end
  endtask

  task automatic test_reset();
    int lows;
    int dones;
    rstn_i     = 1'b0;
    tx_start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (tx_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: got %b, required 1", tx_o);
    end
    checks++;
    if (tx_done_tick_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b, required 0", tx_done_tick_o);
    end
    rstn_i = 1'b1;
    lows   = 0;
    dones  = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) lows++;
      if (tx_done_tick_o !== 1'b0) dones++;
    end
    $display("reset: released, idle low cycles=%0d done cycles=%0d", lows, dones);
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("FAIL reset_idle_tx: %0d low cycles, required 0", lows);
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_idle_done: %0d done cycles, required 0", dones);
    end
  endtask

  task automatic test_single_byte();
    int gap;
    drive_start(8'hAB, 4, 1'b1);
    capture_frame("single_ab", gap);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4] = '{8'hAB, 8'hCD, 8'h12, 8'h34};
    fork
      begin
        drive_start(bytes[0], 868, 1'b1);
        for (int i = 1; i < 4; i++) begin
          int waited;
          waited = 0;
          do begin
            @(negedge clk_i);
            waited++;
          end while (tx_done_tick_o !== 1'b1 && waited < 9000);
          if (tx_done_tick_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL b2b_done_wait: no done tick within %0d cycles, required one", waited);
            break;
          end
          drive_start(bytes[i], 868, 1'b1);
        end
      end
      begin
        for (int i = 0; i < 4; i++) begin
          int gap;
          capture_frame("b2b", gap);
          if (i > 0) begin
            checks++;
            if (gap !== 0) begin
              errors++;
              $display("FAIL b2b_gap: frame %0d extra idle cycles=%0d, required 0", i, gap);
            end
          end
        end
      end
    join
  endtask

  task automatic test_busy_ignore();
    int gap;
    int lows;
    int dones;
    fork
      begin
        drive_start(8'h00, 4, 1'b1);
        repeat (14) @(negedge clk_i);
        din_i      = 8'hFF;
        baud_div   = 16'd1;
        tx_start_i = 1'b1;
        @(negedge clk_i);
        tx_start_i = 1'b0;
      end
      capture_frame("busy", gap);
    join
    lows  = 0;
    dones = 0;
    repeat (60) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) lows++;
      if (tx_done_tick_o !== 1'b0) dones++;
    end
    $display("busy: after frame low cycles=%0d done cycles=%0d", lows, dones);
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("FAIL busy_queued: %0d low cycles after frame, required 0", lows);
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL busy_extra_done: %0d extra done cycles, required 0", dones);
    end
  endtask

  task automatic test_edge_div();
    int gap;
    drive_start(8'h55, 1, 1'b1);
    capture_frame("div1", gap);
    drive_start(8'h55, 0, 1'b1);
    capture_frame("div0", gap);
  endtask

  task automatic test_midframe_reset();
    int gap;
    int lows;
    int dones;
    drive_start(8'h0F, 4, 1'b0);
    repeat (21) @(negedge clk_i);
    checks++;
    if (tx_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pre: data bit 4 of 0x0F got %b, required 0", tx_o);
    end
    rstn_i = 1'b0;
    #1;
    $display("midreset: asserted during data, tx_o=%b done=%b", tx_o, tx_done_tick_o);
    checks++;
    if (tx_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_tx: got %b, required 1", tx_o);
    end
    checks++;
    if (tx_done_tick_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_done: got %b, required 0", tx_done_tick_o);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    lows   = 0;
    dones  = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) lows++;
      if (tx_done_tick_o !== 1'b0) dones++;
    end
    checks++;
    if (lows !== 0 || dones !== 0) begin
      errors++;
      $display("FAIL midreset_quiet: low=%0d done=%0d, required 0 and 0", lows, dones);
    end
    drive_start(8'h3C, 3, 1'b1);
    capture_frame("after_reset", gap);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_busy_ignore();
    test_edge_div();
    test_midframe_reset();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d frames never seen, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
